// File: rtl/unit_output_buf.sv
// Record output buffer: the CPU fills up to 2^(UOB_ADDR_MSB+1) 32-bit words, then the
// consumer streams them out as 16-bit half-words, low half first.
module unit_output_buf #(
  parameter int unsigned UOB_ADDR_MSB = 3,
  parameter int unsigned OUT_WIDTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wr_en,
  input  logic [UOB_ADDR_MSB:0] wr_addr,
  input  logic [31:0]           din,
  input  logic                  set_input_complete,
  output logic                  ready,
  output logic                  full,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  rd_en
);

  localparam int unsigned ADDR_W = UOB_ADDR_MSB + 1;
  localparam int unsigned CNT_W  = UOB_ADDR_MSB + 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] last_ptr_d;
  logic             full_d, ready_d, out_valid_d, out_last_d;
  logic             wr_top;
  logic             mem_we;
  logic [31:0]      mem [DEPTH];
  logic [31:0]      rd_word;

  assign wr_cnt = CNT_W'(wr_addr) + CNT_W'(1);
  assign wr_top = (wr_addr == ADDR_W'(DEPTH - 1));

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    ptr_d      = ptr_q;
    full_d     = full;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        full_d = 1'b0;
        ptr_d  = '0;
        if (wr_en) begin
          mem_we     = 1'b1;
          word_cnt_d = wr_cnt;
          full_d     = wr_top;
          if (set_input_complete) begin
            state_d = ST_OUT;
            full_d  = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (wr_en) begin
          mem_we = 1'b1;
          if (wr_cnt > word_cnt_q) word_cnt_d = wr_cnt;
          if (wr_top) full_d = 1'b1;
        end
        if (set_input_complete) begin
          state_d = ST_OUT;
          full_d  = 1'b1;
        end
      end
      ST_OUT: begin
        full_d = 1'b1;
        if (rd_en) begin
          if (out_last) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            ptr_d      = '0;
            full_d     = 1'b0;
          end else begin
            ptr_d = ptr_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        word_cnt_d = '0;
        ptr_d      = '0;
        full_d     = 1'b0;
      end
    endcase
    ready_d     = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
    // Upper half of word word_cnt-1; the doubling drops the count MSB so 2*depth-1 falls out
    last_ptr_d  = {word_cnt_d[ADDR_W-1:0], 1'b0} - CNT_W'(1);
    out_last_d  = out_valid_d && (ptr_d == last_ptr_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      ptr_q      <= '0;
      ready      <= 1'b1;
      full       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      ptr_q      <= ptr_d;
      ready      <= ready_d;
      full       <= full_d;
      out_valid  <= out_valid_d;
      out_last   <= out_last_d;
    end
  end

  // Storage is never cleared; a new record overwrites what it needs
  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_addr] <= din;
  end

  assign rd_word = mem[ptr_q[CNT_W-1:1]];
  assign dout    = ptr_q[0] ? OUT_WIDTH'(rd_word[31:16]) : OUT_WIDTH'(rd_word[15:0]);

endmodule
